// File: rtl/mc_datapath_if.sv
// rtl/mc_datapath_if.sv - controller/memory-facing signal bundle of the multicycle RV32I datapath
//
// Signals:
//   ImmSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0], AdrSrc,
//   ALUControl[2:0], IRWrite, PCWrite, RegWrite   controller -> datapath
//   ReadData[31:0]                                memory     -> datapath
//   Adr[31:0], WriteData[31:0]                    datapath   -> memory
//   op[6:0], funct3[2:0], funct7b5, Zero          datapath   -> controller
//
// Modports: master is the controller/memory side, slave is the datapath.

interface mc_datapath_if;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic        AdrSrc;
    logic [2:0]  ALUControl;
    logic        IRWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic [31:0] ReadData;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;

    modport master (
        output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
               IRWrite, PCWrite, RegWrite, ReadData,
        input  Adr, WriteData, op, funct3, funct7b5, Zero
    );

    modport slave (
        input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
               IRWrite, PCWrite, RegWrite, ReadData,
        output Adr, WriteData, op, funct3, funct7b5, Zero
    );
endinterface

// File: rtl/mc_datapath.sv
// rtl/mc_datapath.sv - multicycle RV32I datapath (PC, register file, nonarchitectural registers, ALU)
//
// Ports:
//   clk    in   sole clock, rising edge
//   reset  in   synchronous, active-high; clears PC, OldPC, Instr, Data, A, B, ALUOut
//   bus    slave modport of mc_datapath_if: control inputs from the controller,
//          unified memory port (Adr/WriteData/ReadData) and decode feedback
//          (op/funct3/funct7b5/Zero) to the controller.

module mc_datapath (
    input  logic         clk,
    input  logic         reset,
    mc_datapath_if.slave bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] pc_q,     pc_d;
    logic [31:0] oldpc_q,  oldpc_d;
    logic [31:0] instr_q,  instr_d;
    logic [31:0] data_q,   data_d;
    logic [31:0] a_q,      a_d;
    logic [31:0] b_q,      b_d;
    logic [31:0] aluout_q, aluout_d;

    // Entry 0 is never written, so it is never read either: the read muxes
    // force x0 to zero independently of the array contents.
    logic [31:0] rf_q [32];

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic [31:0] result;

    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];
    assign rd  = instr_q[11:7];

    // Reads see the contents before any write on the coming edge, so a
    // same-cycle write to rs1/rs2 becomes visible one cycle later.
    assign rd1 = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rd2 = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    always_comb begin
        imm_ext = 32'd0;
        case (bus.ImmSrc)
            2'b00: imm_ext = {{20{instr_q[31]}}, instr_q[31:20]};
            2'b01: imm_ext = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            2'b10: imm_ext = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25],
                              instr_q[11:8], 1'b0};
            2'b11: imm_ext = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20],
                              instr_q[30:21], 1'b0};
            default: imm_ext = 32'd0;
        endcase
    end

    always_comb begin
        src_a = 32'd0;
        case (bus.ALUSrcA)
            2'b00:   src_a = pc_q;
            2'b01:   src_a = oldpc_q;
            2'b10:   src_a = a_q;
            default: src_a = 32'd0;
        endcase
    end

    always_comb begin
        src_b = 32'd0;
        case (bus.ALUSrcB)
            2'b00:   src_b = b_q;
            2'b01:   src_b = imm_ext;
            2'b10:   src_b = 32'd4;
            default: src_b = 32'd0;
        endcase
    end

    // slt compares as signed values directly rather than looking at the sign
    // of the difference, so it stays correct when the subtraction overflows.
    always_comb begin
        alu_result = 32'd0;
        case (bus.ALUControl)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
    end

    always_comb begin
        result = aluout_q;
        case (bus.ResultSrc)
            2'b00:   result = aluout_q;
            2'b01:   result = data_q;
            2'b10:   result = alu_result;
            default: result = aluout_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        oldpc_d  = oldpc_q;
        instr_d  = instr_q;
        data_d   = bus.ReadData;
        a_d      = rd1;
        b_d      = rd2;
        aluout_d = alu_result;

        // On a fetch (IRWrite with PCWrite) OldPC takes the PC that addressed
        // the instruction, not the incremented one.
        if (bus.IRWrite) begin
            instr_d = bus.ReadData;
            oldpc_d = pc_q;
        end
        if (bus.PCWrite) begin
            pc_d = result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= 32'd0;
            oldpc_q  <= 32'd0;
            instr_q  <= 32'd0;
            data_q   <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
        end else begin
            pc_q     <= pc_d;
            oldpc_q  <= oldpc_d;
            instr_q  <= instr_d;
            data_q   <= data_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end

    // Register file is not cleared by reset, but reset still blocks a write
    // so that an interrupted instruction cannot retire into it.
    always_ff @(posedge clk) begin
        if (!reset && bus.RegWrite && (rd != 5'd0)) begin
            rf_q[rd] <= result;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.Adr       = bus.AdrSrc ? result : pc_q;
    assign bus.WriteData = b_q;
    assign bus.op        = instr_q[6:0];
    assign bus.funct3    = instr_q[14:12];
    assign bus.funct7b5  = instr_q[30];
    assign bus.Zero      = (alu_result == 32'd0);

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multicycle RV32I datapath driven by `controller`. Holds the architectural state (PC, 32×32 register file) and the nonarchitectural registers (OldPC, Instr, Data, A, B, ALUOut). It feeds `op`, `funct3`, `funct7b5` and `Zero` back to the controller. It presents a single unified instruction/data memory port, and the memory's write enable is driven directly by the controller's `MemWrite`.

## Interface
- No parameters. Data width is fixed at 32 bits and the register file holds 32 entries.
- `clk  in  1`: sole clock; all state updates on the rising edge.
- `reset  in  1`: synchronous, active-high.
- `ImmSrc  in  2`: immediate format. 00=I, 01=S, 10=B, 11=J.
- `ALUSrcA  in  2`: ALU A operand. 00=PC, 01=OldPC, 10=A, 11=0.
- `ALUSrcB  in  2`: ALU B operand. 00=B, 01=ImmExt, 10=32'd4, 11=0.
- `ResultSrc  in  2`: Result select. 00=ALUOut, 01=Data, 10=ALUResult, 11=ALUOut.
- `AdrSrc  in  1`: memory address select. 0=PC, 1=Result.
- `ALUControl  in  3`: 000 add, 001 sub, 010 and, 011 or, 101 slt. All other codes produce 0.
- `IRWrite  in  1`: load Instr and OldPC.
- `PCWrite  in  1`: load PC from Result.
- `RegWrite  in  1`: write Result to register file entry `rd`.
- `ReadData  in  32`: memory read data (combinational read).
- `Adr  out  32`: memory address.
- `WriteData  out  32`: store data; equals the B register.
- `op  out  7`: Instr[6:0].
- `funct3  out  3`: Instr[14:12].
- `funct7b5  out  1`: Instr[30].
- `Zero  out  1`: high when ALUResult == 0 (combinational).

## Operation
- **Instruction fields:** rs1=Instr[19:15], rs2=Instr[24:20], rd=Instr[11:7].
- **Register file reads:** RD1/RD2 are combinational reads of rs1/rs2. Entry x0 always reads 0.
- **Register file write:** on the clock edge when RegWrite=1 and rd≠0. A write to x0 is discarded.
- **Immediate extension (ImmExt, all sign-extended from Instr[31]):**
  - I: Instr[31:20].
  - S: {Instr[31:25], Instr[11:7]}.
  - B: {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}.
  - J: {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}.
- **ALU:**
  - add/sub are modulo 2^32; carry and overflow are discarded.
  - slt is a signed compare and returns 32'd1 or 32'd0. It must be correct when A−B overflows (e.g. 0x80000000 slt 0x7FFFFFFF = 1).
- **Registers updated every cycle:** Data←ReadData, A←RD1, B←RD2, ALUOut←ALUResult.
- **Enabled registers:**
  - On IRWrite=1: Instr←ReadData and OldPC←PC.
  - On PCWrite=1: PC←Result.
- **Output muxes:**
  - Result is the ResultSrc mux output.
  - Adr = AdrSrc ? Result : PC.
- **Simultaneous events:**
  - IRWrite and PCWrite together (fetch): OldPC captures the pre-update PC; PC takes PC+4.
  - RegWrite with rs1/rs2 = rd in the same cycle: reads return the old value; the new value is visible the next cycle.
- **Reset:**
  - Clears PC, OldPC, Instr, Data, A, B and ALUOut to 0 on the edge. Reset overrides all enables.
  - Register file contents are not reset; x0 stays 0.
  - After reset: `op`=0, `Adr`=0, `WriteData`=0. Zero reflects the current ALU inputs.
  - Reset asserted mid-instruction has the same effect; no partial state survives beyond the register file.

## Timing
- One controller state per clock cycle. Every register updates on the rising edge that ends the state asserting its control.
- `Zero`, `Adr`, `Result` and ALUResult are combinational from the current register contents and control inputs within the same cycle. No extra pipeline delay.
- **Fetch:** ReadData is sampled at the end of the fetch cycle. `op`/`funct3`/`funct7b5` are valid from the next cycle (decode) onward and remain stable until the next IRWrite.
- **Register reads:** A/B hold the rs1/rs2 values one cycle after decode.
- **Memory access:** memory address computed in cycle n appears on `Adr` in cycle n+1 via ALUOut (AdrSrc=1, ResultSrc=00). Load data lands in Data one cycle later.
- **Branch:** PC update in the beq cycle occurs only if the controller raises PCWrite, which it does from `Zero` in that same cycle. The target comes from ALUOut computed in decode (OldPC+ImmExt).

## Test plan
- **Reset:** assert reset for 2 cycles with random controls → PC=0, Adr=0, op=0, WriteData=0 after release.
- **Fetch:**
  - Stimulus: ReadData=0x00500093 with IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - Response: next cycle PC=4, OldPC=0, op=0010011, funct3=000.
  - Follow with execute (ALUSrcA=10, ALUSrcB=01, ALUControl=000) then writeback (ResultSrc=00, RegWrite=1) → x1=5.
- **x0 protection:** instruction with rd=0 and RegWrite=1, Result=0x1234 → a later read of x0 returns 0.
- **beq:**
  - x2=x3=7, sub executed → Zero=1.
  - x3=8 → Zero=0.
  - Decode-phase ALUOut = OldPC + B-immediate (e.g. imm −8 from OldPC 0x10 → 0x08).
- **lw/sw:**
  - ALUOut=0x40 with AdrSrc=1, ResultSrc=00 → Adr=0x40.
  - Store cycle: WriteData equals rs2 content.
  - Load: ReadData=0xDEADBEEF → Data=0xDEADBEEF next cycle, written to rd with ResultSrc=01.
- **ALU ops and slt:**
  - Signed slt: 0xFFFFFFFF vs 0x00000001 → 1.
  - Overflow case: 0x80000000 vs 0x7FFFFFFF → 1.
  - and/or checked with 0xF0F0F0F0/0x0FF00FF0.
  - ALUControl=111 → 0 and Zero=1.
